// File: rtl/mux_4to1.sv
// mux_4to1 -- parameterized 4:1 selector used as the per-bit source mux in
// front of each flip-flop of the shift/load register.
//   select: 00 keep (slot0), 01 load (slot1), 10 right shift (slot2),
//           11 left shift (slot3). Slot k = data_in[k*WIDTH +: WIDTH].
// data_out is always combinational and independent of clk/reset.
// Build option MUX_4TO1_REG_OUT_EN:
//   defined   -> data_out_q/select_q are captured on rising clk when
//                capture_en=1. They are cleared asynchronously while reset
//                (active-low) is low.
//   undefined -> data_out_q/select_q follow data_out/select combinationally.
//                clk, reset, capture_en and RST_VAL are unused.
module mux_4to1 #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4*WIDTH-1:0]       data_in,
  input  logic [1:0]               select,
  input  logic                     capture_en,
  output logic [WIDTH-1:0]         data_out,
  output logic [WIDTH-1:0]         data_out_q,
  output logic [1:0]               select_q
);

  // Slot selection: all four codes are decoded explicitly.
  always_comb begin
    data_out = '0;
    case (select)
      2'b00: data_out = data_in[0*WIDTH +: WIDTH];
      2'b01: data_out = data_in[1*WIDTH +: WIDTH];
      2'b10: data_out = data_in[2*WIDTH +: WIDTH];
      2'b11: data_out = data_in[3*WIDTH +: WIDTH];
    endcase
  end

`ifdef MUX_4TO1_REG_OUT_EN

  // Registered copy of the selection; the asynchronous reset overrides capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= RST_VAL;
      select_q   <= 2'b00;
    end else if (capture_en) begin
      data_out_q <= data_out;
      select_q   <= select;
    end
  end

`else

  // Pass-through build: the "registered" outputs simply mirror the mux.
  always_comb begin
    data_out_q = data_out;
    select_q   = select;
  end

  // Clock, reset, enable and reset value have no function in this build.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset, capture_en, RST_VAL};

`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1 -- self-checking bench for mux_4to1 (WIDTH=1 and WIDTH=8).
// Follows MUX_4TO1_REG_OUT_EN to pick registered or pass-through expectations.
module tb_mux_4to1;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic [3:0]  din1;
  logic [1:0]  sel1;
  logic        out1, outq1;
  logic [1:0]  selq1;
  logic [31:0] din8;
  logic [1:0]  sel8;
  logic [7:0]  out8, outq8;
  logic [1:0]  selq8;

  mux_4to1 #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .data_in(din1), .select(sel1),
    .capture_en(capture_en), .data_out(out1), .data_out_q(outq1),
    .select_q(selq1)
  );

  mux_4to1 #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
    .clk(clk), .reset(reset), .data_in(din8), .select(sel8),
    .capture_en(capture_en), .data_out(out8), .data_out_q(outq8),
    .select_q(selq8)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] sel;
    logic [3:0] din;
    logic       exp;
  } vec1_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] din;
    logic [7:0]  exp;
  } vec8_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk_q8(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      chk({nm, "_q"}, outq8, e.data);
      chk({nm, "_selq"}, {6'd0, selq8}, {6'd0, e.sel});
    end
  endtask

  // Watchdog: the sequence is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec1_t v1[8];
    vec8_t v8[9];
    logic [7:0] prev_q;

    v1[0] = '{2'd0, 4'b1010, 1'b0};
    v1[1] = '{2'd1, 4'b1010, 1'b1};
    v1[2] = '{2'd2, 4'b1010, 1'b0};
    v1[3] = '{2'd3, 4'b1010, 1'b1};
    v1[4] = '{2'd0, 4'b0110, 1'b0};
    v1[5] = '{2'd1, 4'b0110, 1'b1};
    v1[6] = '{2'd2, 4'b0110, 1'b1};
    v1[7] = '{2'd3, 4'b0110, 1'b0};

    v8[0] = '{2'd1, 32'hD43CB25A, 8'hB2};
    v8[1] = '{2'd3, 32'hD43CB25A, 8'hD4};
    v8[2] = '{2'd0, 32'hD43CB25A, 8'h5A};
    v8[3] = '{2'd0, 32'h01234567, 8'h67};
    v8[4] = '{2'd1, 32'h01234567, 8'h45};
    v8[5] = '{2'd2, 32'h01234567, 8'h23};
    v8[6] = '{2'd3, 32'h01234567, 8'h01};
    v8[7] = '{2'd1, 32'hFF00FF00, 8'hFF};
    v8[8] = '{2'd2, 32'hD43CB25A, 8'h3C};

    reset      = 1'b0;
    capture_en = 1'b1;
    din1       = 4'b0000;
    sel1       = 2'd0;
    din8       = 32'h0;
    sel8       = 2'd0;
    #2;

    // Held in reset with capture_en high and clk running: mux still works.
    for (int i = 0; i < 8; i++) begin
      sel1 = v1[i].sel;
      din1 = v1[i].din;
      #3;
      chk("w1_out", {7'd0, out1}, {7'd0, v1[i].exp});
`ifdef MUX_4TO1_REG_OUT_EN
      chk("w1_rst_q", {7'd0, outq1}, 8'h00);
      chk("w1_rst_selq", {6'd0, selq1}, 8'h00);
`else
      chk("w1_pass_q", {7'd0, outq1}, {7'd0, v1[i].exp});
      chk("w1_pass_selq", {6'd0, selq1}, {6'd0, v1[i].sel});
`endif
    end

`ifdef MUX_4TO1_REG_OUT_EN
    chk("w8_rst_q", outq8, 8'h00);
    chk("w8_rst_selq", {6'd0, selq8}, 8'h00);
    capture_en = 1'b0;
    din8 = 32'hD43CB25A;
    sel8 = 2'd3;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("w8_noen_q", outq8, 8'h00);
      chk("w8_noen_selq", {6'd0, selq8}, 8'h00);
    end
    prev_q = 8'h00;
`else
    reset = 1'b1;
    prev_q = 8'h00;
`endif

    // Main table: drive at negedge, expect capture (or pass-through).
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sel8 = v8[i].sel;
      din8 = v8[i].din;
      capture_en = 1'b1;
      sb.push_back('{v8[i].exp, v8[i].sel});
      #1;
      chk("w8_out", out8, v8[i].exp);
`ifdef MUX_4TO1_REG_OUT_EN
      chk("w8_q_before_edge", outq8, prev_q);
      @(posedge clk);
      #1;
      pop_chk_q8("w8_cap");
      prev_q = v8[i].exp;
`else
      pop_chk_q8("w8_pass");
`endif
    end

`ifdef MUX_4TO1_REG_OUT_EN
    // capture_en low: outputs hold across an edge.
    @(negedge clk);
    capture_en = 1'b0;
    sel8 = 2'd0;
    #1;
    chk("hold_out", out8, 8'h5A);
    @(posedge clk);
    #1;
    chk("hold_q", outq8, 8'h3C);
    chk("hold_selq", {6'd0, selq8}, 8'h02);

    // Reset between edges clears immediately; mux output unaffected.
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_q", outq8, 8'h00);
    chk("midrst_selq", {6'd0, selq8}, 8'h00);
    chk("midrst_out", out8, 8'h5A);

    // Release 1 time unit before an edge: that edge is the first capture.
    sel8 = 2'd3;
    capture_en = 1'b1;
    @(negedge clk);
    #4;
    reset = 1'b1;
    sb.push_back('{8'hD4, 2'd3});
    @(posedge clk);
    #1;
    pop_chk_q8("rel_edge");
`else
    // No clock involvement: reset low, select toggled between edges.
    din8 = 32'hD43CB25A;
    reset = 1'b0;
    @(posedge clk);
    #1;
    sel8 = 2'd0; sb.push_back('{8'h5A, 2'd0}); #1; pop_chk_q8("norst_s0");
    sel8 = 2'd3; sb.push_back('{8'hD4, 2'd3}); #1; pop_chk_q8("norst_s3");
    sel8 = 2'd1; sb.push_back('{8'hB2, 2'd1}); #1; pop_chk_q8("norst_s1");
    capture_en = 1'b0;
    sel8 = 2'd2; sb.push_back('{8'h3C, 2'd2}); #1; pop_chk_q8("norst_s2");
    chk("norst_out", out8, 8'h3C);
    reset = 1'b1;
`endif

    chk("sb_drained", {7'd0, sb.size() == 0}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
